bd8_power_supervisor: RTL and testbench
=======================================

# bd8_power_supervisor

Parametrised power-mode supervisor for the BubbleDrive8 top level. It debounces the board power status (PWRSTAT, MRST) and latches the DIP settings after a settle delay. It selects emulator, MPSSE-standby or error mode, and drives the active-low sub-core enables and status LEDs. Unlike the previous fixed startup FSM, it has configurable blink/settle/debounce timing and leaves emulator mode when power is lost.

## Interface
- BLINK_DIV, 8192: MCLK cycles per blink tick (≥2)
- SETTLE_TICKS, 4: blink ticks spent in SETTLE before evaluation (≥1)
- DEBOUNCE_CYCLES, 16: consecutive equal synchronised samples required to accept a PWRSTAT/MRST change (≥1)
- SETW, 10: width of latched settings bus
- RETRY_TICKS, 64: error auto-retry timeout in blink ticks (used only with macro)
- MCLK in 1: 48 MHz clock, sole clock
- RST in 1: reset, asynchronous, active-high
- PWRSTAT in 1: 0 = motherboard power, 1 = USB power (asynchronous)
- MRST in 1: PCB power status (asynchronous)
- SETTINGS_IN in SETW: raw active-low switch bus
- nDELAYING in 1: delay-in-progress flag from tempsense core
- SETTINGS out SETW: inverted SETTINGS_IN, latched on RESET exit
- nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN out 1 each: active-low sub-core enables
- nLED_PWROK, nLED_STANDBY, nLED_DELAYING out 1 each: active-low LEDs
- STATE out 3: current state code, debug

## Operation
- Input path: 2-FF synchroniser per input. Each input then has a debounce counter. The debounced value adopts the synchronised value after DEBOUNCE_CYCLES consecutive equal samples that differ from the current debounced value.
  - Debounced reset value is 2'b11 for {PWRSTAT, MRST}.
- Blinker: counter 0..BLINK_DIV-1; tick pulses one cycle at BLINK_DIV-1, and blink toggles on tick.
  - Runs in SETTLE, MPSSE, ERR_MRST and ERR_AMBIG.
  - Elsewhere, counter is held at 0, blink=1 and the tick counter is cleared.
- States, with transitions:
  - RESET: load SETTINGS <= ~SETTINGS_IN; go to SETTLE next cycle.
  - SETTLE: count ticks; go to EVAL on the SETTLE_TICKS-th tick.
  - EVAL: one cycle; decode debounced {PWRSTAT, MRST}:
    - 00 → EMU
    - 01 → ERR_MRST
    - 10 → ERR_AMBIG
    - 11 → MPSSE
  - EMU: stay while debounced pair is 00; otherwise go to RESET.
  - MPSSE: stay while 11; otherwise go to RESET.
  - ERR_MRST: stay while MRST=1; otherwise go to RESET.
  - ERR_AMBIG: stay while pair is 10; otherwise go to RESET.
- Enables (registered from state):
  - EMU: nEMUEN=nTEMPEN=nFIFOEN=0, nMPSSEEN=1.
  - MPSSE: nMPSSEEN=0, others 1.
  - All other states: all 1.
- LEDs:
  - SETTLE: PWROK=blink; others off.
  - EMU: PWROK on; DELAYING=nDELAYING.
  - MPSSE: PWROK on; STANDBY=blink.
  - ERR_MRST: PWROK=STANDBY=blink (in phase).
  - ERR_AMBIG: PWROK=blink, STANDBY=~blink (antiphase).
  - Unlisted LEDs are off (1).
- Unused state codes go to RESET.

## Timing
- Reset values: state RESET, SETTINGS=0, all enables 1, all LEDs 1, blink=1, counters 0, STATE=0.
- Asynchronous RST assertion mid-operation immediately forces all reset values, including enables deasserted.
- Input-to-debounced latency: 2 + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES has no effect.
- Enable/LED outputs lag the state register by exactly 1 cycle.
- Reset release to EVAL: 1 (RESET) + SETTLE_TICKS·BLINK_DIV cycles.
- Power-loss exit: debounced change → RESET next cycle → enables deasserted the cycle after.
- A debounced change landing in the same cycle as the EVAL decode: EVAL uses the pre-change (registered) value; the following state then re-checks the new value.

## Configuration
- BD8_SUPERVISOR_RETRY_EN defined:
  - ERR_MRST and ERR_AMBIG also go to RESET after RETRY_TICKS blink ticks in the state.
  - The tick count restarts on each entry.
- Not defined: error states exit only on input change, and the retry counter is absent.

## Structure
- Package bd8_supervisor_pkg holds:
  - state enum and 3-bit codes: RESET=0, SETTLE=1, EVAL=2, EMU=3, MPSSE=4, ERR_MRST=5, ERR_AMBIG=6;
  - LED-mode enum (OFF, ON, BLINK, BLINK_INV, PASS);
  - clog2-based counter width helpers.
- One sub-module, bd8_debounce: synchroniser plus debounce counter, parametrised by DEBOUNCE_CYCLES and width, instanced once for the 2-bit {PWRSTAT, MRST} bus.

## Test plan
- BLINK_DIV=4, SETTLE_TICKS=2, pair=00 → EVAL at cycle 9 after reset release, EMU at 10, nEMUEN=0 at 11, nMPSSEEN=1.
- In EMU, MRST=1 held 20 cycles (DEBOUNCE_CYCLES=16) → RESET 19 cycles after the edge, all enables 1 one cycle later; a 10-cycle MRST pulse causes no change.
- Pair=11 → MPSSE, nMPSSEEN=0, nLED_STANDBY toggles every 4 cycles, nLED_PWROK=0.
- Pair=10 → ERR_AMBIG, nLED_PWROK and nLED_STANDBY always opposite; with BD8_SUPERVISOR_RETRY_EN and RETRY_TICKS=3, RESET after 12 cycles.
- SETTINGS_IN=10'h3F0 at reset → SETTINGS=10'h00F; RST asserted mid-EMU → enables 1 and STATE=0 without an MCLK edge.

Source files
------------

// File: rtl/bd8_supervisor_pkg.sv
// Shared types and helpers for the BubbleDrive8 power supervisor: state codes,
// LED drive modes and counter-width helpers.
package bd8_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_EVAL      = 3'd2,
        ST_EMU       = 3'd3,
        ST_MPSSE     = 3'd4,
        ST_ERR_MRST  = 3'd5,
        ST_ERR_AMBIG = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        LED_OFF,
        LED_ON,
        LED_BLINK,
        LED_BLINK_INV,
        LED_PASS
    } led_mode_e;

    typedef struct packed {
        led_mode_e pwrok;
        led_mode_e standby;
        led_mode_e delaying;
    } led_cfg_t;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic led_cfg_t led_cfg(input logic [2:0] st);
        led_cfg_t c;
        c = '{pwrok: LED_OFF, standby: LED_OFF, delaying: LED_OFF};
        case (st)
            ST_SETTLE:    c.pwrok = LED_BLINK;
            ST_EMU:       begin c.pwrok = LED_ON;    c.delaying = LED_PASS;     end
            ST_MPSSE:     begin c.pwrok = LED_ON;    c.standby  = LED_BLINK;    end
            ST_ERR_MRST:  begin c.pwrok = LED_BLINK; c.standby  = LED_BLINK;    end
            ST_ERR_AMBIG: begin c.pwrok = LED_BLINK; c.standby  = LED_BLINK_INV; end
            default:      c = '{pwrok: LED_OFF, standby: LED_OFF, delaying: LED_OFF};
        endcase
        return c;
    endfunction

    // Active-low LED level for a given mode.
    function automatic logic led_drive(input led_mode_e m, input logic blink, input logic pass);
        case (m)
            LED_ON:        return 1'b0;
            LED_BLINK:     return blink;
            LED_BLINK_INV: return ~blink;
            LED_PASS:      return pass;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/bd8_debounce.sv
// Two-flop synchroniser followed by an independent debounce counter per bit;
// a bit's output follows its input after DEBOUNCE_CYCLES stable differing samples.
module bd8_debounce
    import bd8_supervisor_pkg::*;
#(
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter int                WIDTH           = 2,
    parameter logic [WIDTH-1:0]  RST_VAL         = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [WIDTH-1:0]         deb_q, deb_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Synchronisers reset to the debounced value so reset exit sees no false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            deb_q   <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/bd8_power_supervisor.sv
// Power-mode supervisor: debounces {PWRSTAT, MRST}, selects EMU/MPSSE/error mode,
// drives the sub-core enables and LEDs. Define BD8_SUPERVISOR_RETRY_EN for error auto-retry.
module bd8_power_supervisor
    import bd8_supervisor_pkg::*;
#(
    parameter int BLINK_DIV       = 8192,
    parameter int SETTLE_TICKS    = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETW            = 10,
    parameter int RETRY_TICKS     = 64
) (
    input  logic            MCLK,
    input  logic            RST,
    input  logic            PWRSTAT,
    input  logic            MRST,
    input  logic [SETW-1:0] SETTINGS_IN,
    input  logic            nDELAYING,
    output logic [SETW-1:0] SETTINGS,
    output logic            nEMUEN,
    output logic            nTEMPEN,
    output logic            nFIFOEN,
    output logic            nMPSSEEN,
    output logic            nLED_PWROK,
    output logic            nLED_STANDBY,
    output logic            nLED_DELAYING,
    output logic [2:0]      STATE
);

    localparam int BW       = cnt_width(BLINK_DIV);
    localparam int TICK_SAT = imax(SETTLE_TICKS, RETRY_TICKS);
    localparam int TW       = cnt_width(TICK_SAT + 1);

    logic [1:0]      pair_q;
    logic [2:0]      state_q, state_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SETW-1:0] settings_q, settings_d;
    logic [3:0]      en_q, en_d;
    logic [2:0]      led_q, led_d;
    logic            blink_run;
    logic            tick;
    led_cfg_t        cfg;

    bd8_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .WIDTH           (2),
        .RST_VAL         (2'b11)
    ) u_debounce (
        .clk  (MCLK),
        .rst  (RST),
        .din  ({PWRSTAT, MRST}),
        .dout (pair_q)
    );

    always_comb begin
        blink_run = (state_q == ST_SETTLE) || (state_q == ST_MPSSE) ||
                    (state_q == ST_ERR_MRST) || (state_q == ST_ERR_AMBIG);
        tick      = blink_run && (blink_cnt_q == BW'(BLINK_DIV - 1));

        blink_cnt_d = '0;
        blink_d     = 1'b1;
        tick_cnt_d  = '0;
        if (blink_run) begin
            blink_cnt_d = tick ? '0 : blink_cnt_q + BW'(1);
            blink_d     = tick ? ~blink_q : blink_q;
            tick_cnt_d  = (tick && tick_cnt_q != TW'(TICK_SAT)) ? tick_cnt_q + TW'(1) : tick_cnt_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        settings_d = settings_q;
        case (state_q)
            ST_RESET: begin
                settings_d = ~SETTINGS_IN;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tick && tick_cnt_q == TW'(SETTLE_TICKS - 1)) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                case (pair_q)
                    2'b00:   state_d = ST_EMU;
                    2'b01:   state_d = ST_ERR_MRST;
                    2'b10:   state_d = ST_ERR_AMBIG;
                    default: state_d = ST_MPSSE;
                endcase
            end
            ST_EMU:   if (pair_q != 2'b00) state_d = ST_RESET;
            ST_MPSSE: if (pair_q != 2'b11) state_d = ST_RESET;
            ST_ERR_MRST: begin
                if (!pair_q[0]) state_d = ST_RESET;
`ifdef BD8_SUPERVISOR_RETRY_EN
                else if (tick && tick_cnt_q == TW'(RETRY_TICKS - 1)) state_d = ST_RESET;
`endif
            end
            ST_ERR_AMBIG: begin
                if (pair_q != 2'b10) state_d = ST_RESET;
`ifdef BD8_SUPERVISOR_RETRY_EN
                else if (tick && tick_cnt_q == TW'(RETRY_TICKS - 1)) state_d = ST_RESET;
`endif
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Enables and LEDs are registered from the current state, one cycle behind it.
    always_comb begin
        case (state_q)
            ST_EMU:   en_d = 4'b0001;
            ST_MPSSE: en_d = 4'b1110;
            default:  en_d = 4'b1111;
        endcase
        cfg   = led_cfg(state_q);
        led_d = {led_drive(cfg.pwrok,    blink_q, 1'b1),
                 led_drive(cfg.standby,  blink_q, 1'b1),
                 led_drive(cfg.delaying, blink_q, nDELAYING)};
    end

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RESET;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            tick_cnt_q  <= '0;
            settings_q  <= '0;
            en_q        <= 4'b1111;
            led_q       <= 3'b111;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            tick_cnt_q  <= tick_cnt_d;
            settings_q  <= settings_d;
            en_q        <= en_d;
            led_q       <= led_d;
        end
    end

    assign SETTINGS = settings_q;
    assign {nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN} = en_q;
    assign {nLED_PWROK, nLED_STANDBY, nLED_DELAYING} = led_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_bd8_power_supervisor.sv
// Directed bench for bd8_power_supervisor with short blink/settle timing.
// Cycle numbers in comments count MCLK rising edges after the relevant event.
module tb_bd8_power_supervisor;

    localparam int BLINK_DIV       = 4;
    localparam int SETTLE_TICKS    = 2;
    localparam int DEBOUNCE_CYCLES = 16;
    localparam int SETW            = 10;
    localparam int RETRY_TICKS     = 3;

    logic            MCLK = 1'b0;
    logic            RST;
    logic            PWRSTAT;
    logic            MRST;
    logic [SETW-1:0] SETTINGS_IN;
    logic            nDELAYING;
    logic [SETW-1:0] SETTINGS;
    logic            nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN;
    logic            nLED_PWROK, nLED_STANDBY, nLED_DELAYING;
    logic [2:0]      STATE;

    int checks = 0;
    int errors = 0;

    bd8_power_supervisor #(
        .BLINK_DIV       (BLINK_DIV),
        .SETTLE_TICKS    (SETTLE_TICKS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SETW            (SETW),
        .RETRY_TICKS     (RETRY_TICKS)
    ) dut (
        .MCLK          (MCLK),
        .RST           (RST),
        .PWRSTAT       (PWRSTAT),
        .MRST          (MRST),
        .SETTINGS_IN   (SETTINGS_IN),
        .nDELAYING     (nDELAYING),
        .SETTINGS      (SETTINGS),
        .nEMUEN        (nEMUEN),
        .nTEMPEN       (nTEMPEN),
        .nFIFOEN       (nFIFOEN),
        .nMPSSEEN      (nMPSSEEN),
        .nLED_PWROK    (nLED_PWROK),
        .nLED_STANDBY  (nLED_STANDBY),
        .nLED_DELAYING (nLED_DELAYING),
        .STATE         (STATE)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance n rising edges and sample 1 ns later.
    task automatic step(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
        int n = 0;
        while (STATE !== code && n < budget) begin
            step(1);
            n++;
        end
        check(tag, {29'd0, STATE}, {29'd0, code});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST         = 1'b0;
        PWRSTAT     = 1'b1;
        MRST        = 1'b1;
        SETTINGS_IN = 10'h3F0;
        nDELAYING   = 1'b1;
        #2 RST = 1'b1;
        step(3);
        check("rst_state",    STATE, 0);
        check("rst_settings", SETTINGS, 0);
        check("rst_en",       {nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN}, 4'hF);
        check("rst_led",      {nLED_PWROK, nLED_STANDBY, nLED_DELAYING}, 3'h7);

        // Reset release with pair 11 (matches debounced reset value).
        RST = 1'b0;
        step(1);                                        // edge 1
        check("settle_entry",   STATE, 1);
        check("settings_latch", SETTINGS, 10'h00F);
        step(4);                                        // edge 5
        check("settle_blink_hi", nLED_PWROK, 1);
        step(1);                                        // edge 6
        check("settle_blink_lo", nLED_PWROK, 0);
        step(3);                                        // edge 9
        check("eval_at_9", STATE, 2);
        step(1);                                        // edge 10
        check("mpsse_at_10", STATE, 4);
        check("mpsseen_lag", nMPSSEEN, 1);
        step(1);                                        // edge 11
        check("mpsseen_on", nMPSSEEN, 0);
        check("mpsse_emuen_off", nEMUEN, 1);
        for (int k = 11; k <= 22; k++) begin
            check("mpsse_standby", nLED_STANDBY, (((k - 11) / 4) % 2 == 1) ? 0 : 1);
            check("mpsse_pwrok", nLED_PWROK, 0);
            step(1);
        end

        // Drop to pair 00: power-loss exit from MPSSE, then EMU.
        PWRSTAT = 1'b0;
        MRST    = 1'b0;
        step(18);
        check("mpsse_hold_18", STATE, 4);
        step(1);
        check("mpsse_exit_19", STATE, 0);
        check("mpsse_en_lag", nMPSSEEN, 0);
        step(1);
        check("mpsse_en_off", nMPSSEEN, 1);
        check("resettle", STATE, 1);
        step(8);
        check("eval2", STATE, 2);
        step(1);
        check("emu_entry", STATE, 3);
        check("emu_en_lag", nEMUEN, 1);
        step(1);
        check("emu_en", {nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN}, 4'b0001);
        check("emu_led", {nLED_PWROK, nLED_STANDBY}, 2'b01);

        nDELAYING = 1'b0;
        step(1);
        check("delaying_on", nLED_DELAYING, 0);
        nDELAYING = 1'b1;
        step(1);
        check("delaying_off", nLED_DELAYING, 1);

        // 10-cycle MRST glitch is filtered.
        MRST = 1'b1;
        step(10);
        MRST = 1'b0;
        step(30);
        check("glitch_state", STATE, 3);
        check("glitch_en", nEMUEN, 0);

        // MRST held: leave EMU, then land in ERR_MRST.
        MRST = 1'b1;
        step(18);
        check("emu_hold_18", STATE, 3);
        step(1);
        check("emu_exit_19", STATE, 0);
        check("emu_en_lag_exit", nEMUEN, 0);
        step(1);
        check("emu_en_off", {nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN}, 4'hF);
        step(8);
        check("eval3", STATE, 2);
        step(1);
        check("err_mrst_entry", STATE, 5);
        for (int j = 1; j <= 10; j++) begin
            step(1);
            check("err_mrst_pwrok",   nLED_PWROK,   (((j - 1) / 4) % 2 == 1) ? 0 : 1);
            check("err_mrst_standby", nLED_STANDBY, (((j - 1) / 4) % 2 == 1) ? 0 : 1);
        end
        check("err_mrst_en", {nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN}, 4'hF);

        // Pair 10: ERR_AMBIG with antiphase LEDs.
        PWRSTAT = 1'b1;
        MRST    = 1'b0;
        wait_state(3'd6, 300, "reach_ambig");
        for (int j = 1; j <= 11; j++) begin
            step(1);
            check("ambig_state",   STATE, 6);
            check("ambig_pwrok",   nLED_PWROK,   (((j - 1) / 4) % 2 == 1) ? 0 : 1);
            check("ambig_standby", nLED_STANDBY, (((j - 1) / 4) % 2 == 1) ? 1 : 0);
        end
        step(1);
`ifdef BD8_SUPERVISOR_RETRY_EN
        check("ambig_retry_12", STATE, 0);
`else
        check("ambig_hold_12", STATE, 6);
        step(8);
        check("ambig_hold_20", STATE, 6);
`endif

        // Back to EMU, then asynchronous reset between clock edges.
        PWRSTAT = 1'b0;
        wait_state(3'd3, 400, "reach_emu");
        step(2);
        check("emu_again_en", nEMUEN, 0);
        #3 RST = 1'b1;
        #1;
        check("async_state",    STATE, 0);
        check("async_en",       {nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN}, 4'hF);
        check("async_settings", SETTINGS, 0);
        check("async_led",      {nLED_PWROK, nLED_STANDBY, nLED_DELAYING}, 3'h7);
        step(2);
        RST = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
